// File: rtl/sipo_pkg.sv
// Shared definitions for the serial link: default frame width and receiver state encoding.
`default_nettype none

package sipo_pkg;

  localparam int SIPO_WIDTH = 4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/sipo_shift_stage.sv
// Receive shift register and bit counter; word presents the frame as it will look after the current bit.
`default_nettype none

module sipo_shift_stage
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift,
  input  logic             restart,
  input  logic             serial_in,
  output logic [WIDTH-1:0] word,
  output logic [CNT_W-1:0] bit_count,
  output logic             last_bit
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] shreg;

  // LSB-first: new bit enters at the top and walks down towards bit 0
  assign word     = {serial_in, shreg[WIDTH-1:1]};
  assign last_bit = (bit_count == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg     <= '0;
      bit_count <= '0;
    end else if (shift) begin
      shreg <= word;
      if (restart)
        bit_count <= CNT_W'(1);
      else if (bit_count == LAST_IDX)
        bit_count <= '0;
      else
        bit_count <= bit_count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sipo_frame_receiver.sv
// Serial-to-parallel frame receiver: FSM, one-deep ready/valid hold register, overrun and sync error pulses.
`default_nettype none

module sipo_frame_receiver
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             in_valid,
  input  logic             start,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] bit_count,
  output logic             overrun,
  output logic             sync_err
);

  state_e           state, state_n;
  logic             shift, restart, complete, sync_err_n, last_bit;
  logic [WIDTH-1:0] word;

  sipo_shift_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_stage (
    .clk       (clk),
    .rst       (rst),
    .shift     (shift),
    .restart   (restart),
    .serial_in (serial_in),
    .word      (word),
    .bit_count (bit_count),
    .last_bit  (last_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n    = state;
    shift      = 1'b0;
    restart    = 1'b0;
    complete   = 1'b0;
    sync_err_n = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_valid && start) begin
          shift   = 1'b1;
          restart = 1'b1;
          state_n = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (in_valid) begin
          shift = 1'b1;
          if (start) begin
            // resynchronise on the new frame rather than dropping its first bit
            restart    = 1'b1;
            sync_err_n = 1'b1;
          end else if (last_bit) begin
            complete = 1'b1;
            state_n  = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_SHIFT);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      overrun  <= 1'b0;
      sync_err <= sync_err_n;
      if (complete) begin
        if (!out_valid || out_ready) begin
          out_data  <= word;
          out_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
